// File: rtl/burst_memory.sv
// Byte-addressable big-endian word memory at a fixed base, with single and burst (1/4/8/16) transfers.
// Latency: read beat k appears on data_out k+1 cycles after accept, one beat per cycle; write beats land at the clock edge that samples them.
// Backpressure: write beats stall while enable=0; reads never stall; new requests are ignored while busy.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   enable                request valid in IDLE, write beat valid in WRITE, ignored in READ
//   rw, address,          request attributes, sampled only when a request is accepted
//   access_size
//   data_in               write data for the current beat
//   busy                  high while a burst is in progress
//   data_out, data_out_valid  registered read beat and its qualifier
//   done, error           one-cycle pulses: last beat completed / request rejected
module burst_memory #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH_BYTES = 1048576,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR  = 32'h80020000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  rw,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [1:0]            access_size,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic                  done,
  output logic                  error
);

  localparam int WB  = DATA_WIDTH / 8;
  localparam int MAW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t          state;
  logic [4:0]      beat_cnt;   // index of the next beat to transfer
  logic [4:0]      beat_num;   // burst length latched at accept
  logic [MAW-1:0]  addr_q;     // byte offset of the next beat

  logic [7:0]      mem [DEPTH_BYTES];

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [4:0]            req_n;
  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH:0]   req_end;
  logic                  legal;

  always_comb begin
    req_n = 5'd1;
    case (access_size)
      2'b00:   req_n = 5'd1;
      2'b01:   req_n = 5'd4;
      2'b10:   req_n = 5'd8;
      default: req_n = 5'd16;
    endcase
  end

  assign off = address - START_ADDR;

  // One extra bit so a request that runs past the top of the address space
  // cannot wrap around and appear to fit.
  assign req_end = {1'b0, off} + ((ADDR_WIDTH+1)'(req_n) * (ADDR_WIDTH+1)'(WB));

  assign legal = (address >= START_ADDR)
              && ((off % ADDR_WIDTH'(WB)) == '0)
              && (req_end <= (ADDR_WIDTH+1)'(DEPTH_BYTES));

  // ---------------------------------------------------------------------------
  // Array port: in IDLE the port points at the incoming request so beat 0
  // can be serviced in the accept cycle; afterwards it follows addr_q.
  // ---------------------------------------------------------------------------
  logic [MAW-1:0]        mem_idx;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] rd_word;

  assign mem_idx = (state == IDLE) ? off[MAW-1:0] : addr_q;

  // Reset wins over any write that would otherwise happen on the same edge.
  assign mem_we = !reset
               && (((state == IDLE) && enable && legal && !rw)
                || ((state == WRITE) && enable));

  // Big-endian: the lowest byte address is the most significant byte.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < WB; i++) begin
      rd_word[DATA_WIDTH-1-8*i -: 8] = mem[mem_idx + MAW'(i)];
    end
  end

  // Contents survive reset, so this block has no reset branch.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < WB; i++) begin
        mem[mem_idx + MAW'(i)] <= data_in[DATA_WIDTH-1-8*i -: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      beat_cnt       <= '0;
      beat_num       <= '0;
      addr_q         <= '0;
    end else begin
      done           <= 1'b0;
      error          <= 1'b0;
      data_out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (enable) begin
            if (!legal) begin
              error <= 1'b1;
            end else if (rw) begin
              // Beat 0 is presented straight out of the accept edge.
              state          <= READ;
              busy           <= 1'b1;
              data_out       <= rd_word;
              data_out_valid <= 1'b1;
              done           <= (req_n == 5'd1);
              beat_cnt       <= 5'd1;
              beat_num       <= req_n;
              addr_q         <= off[MAW-1:0] + MAW'(WB);
            end else if (req_n == 5'd1) begin
              // Single-word write finishes in the accept cycle; busy never rises.
              done <= 1'b1;
            end else begin
              state    <= WRITE;
              busy     <= 1'b1;
              beat_cnt <= 5'd1;
              beat_num <= req_n;
              addr_q   <= off[MAW-1:0] + MAW'(WB);
            end
          end
        end

        WRITE: begin
          // enable=0 is a stall: counter and address simply hold.
          if (enable) begin
            addr_q   <= addr_q + MAW'(WB);
            beat_cnt <= beat_cnt + 5'd1;
            if (beat_cnt == beat_num - 5'd1) begin
              done  <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        READ: begin
          // Once every beat has been presented, spend one edge dropping
          // valid/busy; data_out keeps the last beat.
          if (beat_cnt == beat_num) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            data_out       <= rd_word;
            data_out_valid <= 1'b1;
            done           <= (beat_cnt == beat_num - 5'd1);
            beat_cnt       <= beat_cnt + 5'd1;
            addr_q         <= addr_q + MAW'(WB);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_done_error_excl: assert property (@(posedge clock) disable iff (reset)
    !(done && error));

  a_valid_in_burst: assert property (@(posedge clock) disable iff (reset)
    data_out_valid |-> busy);

endmodule

// File: tb/tb_burst_memory.sv
// Self-checking bench for burst_memory: directed cases from the test plan plus random traffic.
// Expected data comes from a byte-level associative-array model of the address space.
// Inputs are driven 1 ns after each rising edge and outputs are sampled at the same point.
module tb_burst_memory;

  localparam int          DW    = 32;
  localparam int          AW    = 32;
  localparam int          DEPTH = 1048576;
  localparam logic [31:0] BASE  = 32'h80020000;

  logic          clock;
  logic          reset;
  logic          enable;
  logic          rw;
  logic [AW-1:0] address;
  logic [1:0]    access_size;
  logic [DW-1:0] data_in;
  logic          busy;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          done;
  logic          error;

  burst_memory #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH_BYTES(DEPTH),
    .START_ADDR (BASE)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .rw            (rw),
    .address       (address),
    .access_size   (access_size),
    .data_in       (data_in),
    .busy          (busy),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .done          (done),
    .error         (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp;
  int n_bad;

  // Reference model: one entry per byte offset that has been written.
  logic [7:0] ref_mem [int unsigned];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int unsigned off);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < 4; b++) begin
      if (ref_mem.exists(off + b)) w[31-8*b -: 8] = ref_mem[off + b];
    end
    return w;
  endfunction

  task automatic ref_store(input int unsigned off, input logic [31:0] w);
    for (int b = 0; b < 4; b++) ref_mem[off + b] = w[31-8*b -: 8];
  endtask

  function automatic int burst_len(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (2 << sz);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Write burst; optionally drops enable for stall_len cycles before beat stall_beat.
  task automatic do_write(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] w[16],
                          input int stall_beat, input int stall_len, output int busy_cyc);
    int n;
    int unsigned off;
    n   = burst_len(sz);
    off = addr - BASE;
    busy_cyc    = 0;
    enable      = 1'b1;
    rw          = 1'b0;
    address     = addr;
    access_size = sz;
    data_in     = w[0];
    tick();
    ref_store(off, w[0]);
    check("wr_err", 32'(error), 32'd0);
    if (busy) busy_cyc++;
    if (n == 1) check("wr1_done", 32'(done), 32'd1);
    for (int k = 1; k < n; k++) begin
      if (k == stall_beat) begin
        for (int s = 0; s < stall_len; s++) begin
          enable      = 1'b0;
          data_in     = $urandom;
          address     = $urandom;
          access_size = 2'($urandom);
          tick();
          check("wr_stall_done", 32'(done), 32'd0);
          if (busy) busy_cyc++;
        end
      end
      enable  = 1'b1;
      data_in = w[k];
      address = $urandom;
      tick();
      ref_store(off + 4 * k, w[k]);
      if (busy) busy_cyc++;
      check("wr_done", 32'(done), 32'(k == n - 1));
    end
    enable = 1'b0;
  endtask

  // Read burst; enable and request fields are scrambled during the burst.
  task automatic do_read(input logic [31:0] addr, input logic [1:0] sz, output int busy_cyc);
    int n;
    int unsigned off;
    logic [31:0] last;
    n   = burst_len(sz);
    off = addr - BASE;
    busy_cyc    = 0;
    last        = '0;
    enable      = 1'b1;
    rw          = 1'b1;
    address     = addr;
    access_size = sz;
    data_in     = $urandom;
    tick();
    for (int k = 0; k < n; k++) begin
      last = ref_word(off + 4 * k);
      check("rd_valid", 32'(data_out_valid), 32'd1);
      check("rd_data", data_out, last);
      check("rd_done", 32'(done), 32'(k == n - 1));
      if (busy) busy_cyc++;
      enable      = 1'($urandom);
      rw          = 1'($urandom);
      address     = $urandom;
      access_size = 2'($urandom);
      tick();
    end
    enable = 1'b0;
    check("rd_end_valid", 32'(data_out_valid), 32'd0);
    check("rd_end_busy", 32'(busy), 32'd0);
    check("rd_hold", data_out, last);
  endtask

  task automatic reject(input logic [31:0] addr, input logic [1:0] sz);
    enable      = 1'b1;
    rw          = 1'($urandom);
    address     = addr;
    access_size = sz;
    data_in     = $urandom;
    tick();
    check("rej_error", 32'(error), 32'd1);
    check("rej_busy", 32'(busy), 32'd0);
    check("rej_done", 32'(done), 32'd0);
    check("rej_valid", 32'(data_out_valid), 32'd0);
    enable = 1'b0;
    tick();
    check("rej_pulse", 32'(error), 32'd0);
    check("rej_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w[16];
    int          bc;
    logic [31:0] a;
    logic [1:0]  sz;
    int          n;
    int          stall_b;
    int          stall_l;
    n_cmp = 0;
    n_bad = 0;

    reset       = 1'b1;
    enable      = 1'b0;
    rw          = 1'b0;
    address     = '0;
    access_size = '0;
    data_in     = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(data_out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_dout", data_out, 32'd0);
    reset = 1'b0;
    tick();

    // Single word write then read.
    for (int i = 0; i < 16; i++) w[i] = '0;
    w[0] = 32'hDEADBEEF;
    do_write(BASE, 2'b00, w, -1, 0, bc);
    check("single_wr_busy", 32'(bc), 32'd0);
    check("byte0", {24'd0, dut.mem[0]}, 32'h000000DE);
    check("byte3", {24'd0, dut.mem[3]}, 32'h000000EF);
    do_read(BASE, 2'b00, bc);
    check("single_rd_busy", 32'(bc), 32'd1);

    // Burst-4 write with a 2-cycle stall before beat 2.
    w[0] = 32'h11111111; w[1] = 32'h22222222; w[2] = 32'h33333333; w[3] = 32'h44444444;
    do_write(BASE + 32'h10, 2'b01, w, 2, 2, bc);
    check("b4_busy", 32'(bc), 32'd5);
    do_read(BASE + 32'h10, 2'b01, bc);
    check("b4_rd_busy", 32'(bc), 32'd4);

    // Burst-16 read of an incrementing pattern.
    for (int i = 0; i < 16; i++) w[i] = 32'(i);
    do_write(BASE, 2'b11, w, -1, 0, bc);
    check("b16_wr_busy", 32'(bc), 32'd15);
    do_read(BASE, 2'b11, bc);
    check("b16_rd_busy", 32'(bc), 32'd16);

    // Preload the rest of the low 512 bytes and the top 64 bytes.
    for (int blk = 1; blk < 8; blk++) begin
      for (int i = 0; i < 16; i++) w[i] = $urandom;
      do_write(BASE + 32'(64 * blk), 2'b11, w, -1, 0, bc);
    end
    for (int i = 0; i < 16; i++) w[i] = $urandom;
    do_write(BASE + 32'(DEPTH - 64), 2'b11, w, -1, 0, bc);

    // Range and alignment errors, then confirm nothing moved.
    reject(32'h80020002, 2'b00);
    reject(32'h8001FFFC, 2'b00);
    reject(BASE + 32'(DEPTH - 16), 2'b10);
    reject(32'hFFFFFFF0, 2'b11);
    do_read(BASE, 2'b11, bc);
    do_read(BASE + 32'(DEPTH - 64), 2'b11, bc);
    // Exactly reaching the top of memory is legal.
    do_read(BASE + 32'(DEPTH - 16), 2'b01, bc);
    check("top_rd_busy", 32'(bc), 32'd4);

    // Reset in the middle of a burst-8 write, after beat 3.
    a = BASE + 32'h100;
    for (int i = 0; i < 8; i++) w[i] = $urandom;
    enable = 1'b1; rw = 1'b0; address = a; access_size = 2'b10; data_in = w[0];
    tick();
    ref_store(a - BASE, w[0]);
    for (int k = 1; k < 4; k++) begin
      data_in = w[k];
      tick();
      ref_store(a - BASE + 4 * k, w[k]);
    end
    reset   = 1'b1;
    data_in = w[4];
    tick();
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_valid", 32'(data_out_valid), 32'd0);
    check("rstw_done", 32'(done), 32'd0);
    check("rstw_error", 32'(error), 32'd0);
    check("rstw_dout", data_out, 32'd0);
    reset = 1'b0;
    do_read(a + 32'h10, 2'b00, bc);
    do_read(a, 2'b10, bc);

    // Reset in the middle of a burst-16 read.
    enable = 1'b1; rw = 1'b1; address = BASE + 32'h40; access_size = 2'b11;
    tick();
    enable = 1'b0;
    tick();
    tick();
    check("rstr_valid_pre", 32'(data_out_valid), 32'd1);
    check("rstr_data_pre", data_out, ref_word(32'h48));
    reset = 1'b1;
    tick();
    check("rstr_valid", 32'(data_out_valid), 32'd0);
    check("rstr_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();
    check("rstr_valid_after", 32'(data_out_valid), 32'd0);

    // Random traffic over the low 512 bytes.
    for (int t = 0; t < 60; t++) begin
      sz = 2'($urandom);
      n  = burst_len(sz);
      a  = BASE + 32'(4 * $urandom_range(0, 128 - n));
      if ($urandom_range(0, 7) == 0) begin
        reject(a + 32'($urandom_range(1, 3)), sz);
      end else if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < 16; i++) w[i] = $urandom;
        stall_b = (n > 1) ? $urandom_range(1, n - 1) : -1;
        stall_l = $urandom_range(0, 3);
        do_write(a, sz, w, stall_b, stall_l, bc);
        check("rnd_wr_busy", 32'(bc), 32'((n == 1) ? 0 : (n - 1 + stall_l)));
      end else begin
        do_read(a, sz, bc);
        check("rnd_rd_busy", 32'(bc), 32'(n));
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/burst_memory.md
Name: burst_memory

Overview:
- Parametrised successor of the unified instruction/data memory.
- Byte-addressable, big-endian, word-wide memory mapped at a fixed base address.
- Adds single and burst transfers (1/4/8/16 words) with a proper state machine, a beat counter, write-data stall handshake, read-data valid, completion pulse and address-range error reporting.
- Sits between the fetch/memory stages and the testbench program loader.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8; WB = DATA_WIDTH/8 bytes per word.
- ADDR_WIDTH, 32, byte-address width.
- DEPTH_BYTES, 1048576, memory size in bytes.
- START_ADDR, 32'h80020000, byte address of memory byte 0.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  In IDLE: request valid. In WRITE: data_in beat valid.
- rw  in  1  1 = read, 0 = write; sampled at accept.
- address  in  ADDR_WIDTH  start byte address; sampled at accept.
- access_size  in  2  00 = 1 word, 01 = 4, 10 = 8, 11 = 16; sampled at accept.
- data_in  in  DATA_WIDTH  write data for the current beat.
- busy  out  1  high while state != IDLE; new requests are ignored while high.
- data_out  out  DATA_WIDTH  registered read data.
- data_out_valid  out  1  high on each cycle data_out carries a read beat.
- done  out  1  one-cycle pulse on the cycle the last beat completes.
- error  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset (reset=1 at a rising edge):
  - State goes to IDLE.
  - busy, data_out_valid, done, error all go to 0; data_out goes to 0; beat counter and address register clear.
  - Memory contents are NOT cleared.
  - Reset has priority over every other event.
- Burst length: N = 1, 4, 8 or 16 for access_size 00/01/10/11.
- Offset: off = address - START_ADDR, computed at ADDR_WIDTH bits. Beat k accesses bytes off+k*WB through off+k*WB+WB-1.
- Byte order (big-endian):
  - byte[a] maps to data[DATA_WIDTH-1 -: 8];
  - byte[a+WB-1] maps to data[7:0].
- Accept:
  - Occurs in IDLE with enable=1.
  - A request is legal only if address >= START_ADDR, off % WB == 0, and off + N*WB <= DEPTH_BYTES (compare at ADDR_WIDTH+1 bits so wrap-around cannot pass).
  - Illegal request: error=1 for one cycle, no memory access, stay in IDLE.
- States: IDLE, WRITE, READ.
- Write:
  - Beat 0 is written from data_in in the accept cycle.
  - N=1: done=1 that same cycle; stay in IDLE, so busy never rises.
  - N>1: go to WRITE, beat counter = 1.
  - In WRITE with enable=1: write the beat at the current address, advance address by WB, increment the counter.
  - In WRITE with enable=0: stall; no write, counter and address hold, busy stays 1.
  - When beat N-1 is written: done=1 that cycle; next state IDLE.
- Read:
  - Accept moves to READ; busy=1 from the next cycle.
  - One beat per cycle with no stall: for N cycles, data_out = beat k and data_out_valid=1, k = 0..N-1.
  - enable is ignored in READ.
  - done=1 on the cycle beat N-1 is presented; next state IDLE.
  - data_out holds its last value after the burst; data_out_valid returns to 0.
- Back-to-back: the first cycle with busy=0 after a burst may accept a new request.
- Read and write use the same array; a read after a completed write returns the new data. There is no same-cycle read/write conflict because there is one request at a time.
- Reset mid-burst:
  - Beats already written remain in memory; remaining beats are dropped.
  - A read in flight is abandoned with data_out_valid=0 from the next cycle.
- Array size: exactly DEPTH_BYTES entries, indexed 0..DEPTH_BYTES-1.

Test Plan:
- Single write/read: write 32'hDEADBEEF at 32'h80020000; then read 1 word at the same address. Required: byte[0]=8'hDE, byte[3]=8'hEF; data_out=32'hDEADBEEF with data_out_valid=1 one cycle after accept; done pulse; busy=1 for exactly 1 cycle.
- Burst-4 write with stall: write 32'h11111111/22222222/33333333/44444444 at 32'h80020010, with enable=0 for 2 cycles before beat 2. Required: busy=1 for 5 cycles; memory at +0/+4/+8/+C holds the four words; no write during the stall.
- Burst-16 read: read 16 words at 32'h80020000 after preloading the incrementing pattern 0..15. Required: 16 consecutive valid cycles, data_out = 0,1,…,15; done on the 16th; busy drops the next cycle.
- Range/alignment errors:
  - 32'h80020002 → error pulse.
  - 32'h8001FFFC → error pulse.
  - Burst-8 at START_ADDR+DEPTH_BYTES-16 → error pulse.
  - In all three cases: busy stays 0 and memory is unchanged.
- Reset mid-write: burst-8 write, assert reset after beat 3. Required: beats 0–3 present, beats 4–7 unchanged; all outputs 0 on the next cycle; a new 1-word read is accepted immediately after.
